uart_rx_buffered: RTL

//   Parametrised UART receiver, the successor to the fixed 8N1 receiver used by the echo example.

---
 rtl/uart_rx_buffered_pkg.sv | 21 ++
 rtl/uart_rx_buffered_sync_fifo.sv | 54 +++++
 rtl/uart_rx_buffered.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the buffered UART receiver: parity modes,
// receiver state encoding and the 2-of-3 vote helper.
package uart_rx_buffered_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// Small first-word-fall-through FIFO: the head word is always visible on
// 'head'. A push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle; otherwise the word is discarded.
module sync_fifo #(
  parameter int W  = 10,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Parametrised UART receiver with 3-sample majority voting, start-glitch
// rejection, framing/parity error flags and a FWFT output FIFO.
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int BAUD   = 104,
  parameter int DW     = 8,
  parameter int PARITY = 0,
  parameter int AW     = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx,
  output logic [DW-1:0] data,
  output logic          frame_err,
  output logic          parity_err,
  output logic          valid,
  input  logic          ready,
  output logic          busy,
  output logic          overrun
);

  localparam int CW = $clog2(BAUD);
  localparam int BW = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD - 1);
  localparam logic [CW-1:0] MID_LO   = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] MID      = CW'(BAUD / 2);
  localparam logic [CW-1:0] MID_HI   = CW'(BAUD / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  rx_state_t       state;
  rx_state_t       next_state;
  logic            sync1;
  logic            rxs;
  logic            armed;
  logic [CW-1:0]   cnt;
  logic            s_lo;
  logic            s_mid;
  logic [BW-1:0]   bit_idx;
  logic [DW-1:0]   shreg;
  logic            par_err;
  logic            at_vote;
  logic            vote;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [DW+1:0]   word_in;
  logic [DW+1:0]   word_out;

  assign at_vote = (cnt == MID_HI);
  assign vote    = majority3(s_lo, s_mid, rxs);

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decisions, all taken at the vote point of the current bit.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (armed && !rxs) next_state = S_START;
      S_START:  if (at_vote) next_state = vote ? S_IDLE : S_DATA;
      S_DATA:   if (at_vote && (bit_idx == BIT_LAST))
                  next_state = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (at_vote) next_state = S_STOP;
      S_STOP:   if (at_vote) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Status and FIFO write strobe derived from the current state.
  always_comb begin
    busy = (state != S_IDLE);
    push = (state == S_STOP) && at_vote;
  end

  // Bit timing, vote samples, data shift register, arming and parity result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      s_lo    <= 1'b1;
      s_mid   <= 1'b1;
      bit_idx <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
      armed   <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        cnt     <= '0;
        bit_idx <= '0;
        if (rxs) begin
          armed <= 1'b1;
        end else if (armed) begin
          armed   <= 1'b0;
          par_err <= 1'b0;
        end
      end else begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
      if (cnt == MID_LO) s_lo  <= rxs;
      if (cnt == MID)    s_mid <= rxs;
      if ((state == S_DATA) && at_vote) begin
        shreg   <= {vote, shreg[DW-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if ((state == S_PARITY) && at_vote)
        par_err <= (PARITY == PAR_ODD) ? ~(^shreg ^ vote) : (^shreg ^ vote);
    end
  end

  assign word_in = {par_err, ~vote, shreg};
  assign pop     = valid && ready;
  assign valid   = !empty;
  assign overrun = push && full && !pop;
  assign {parity_err, frame_err, data} = word_out;

  sync_fifo #(
    .W (DW + 2),
    .AW(AW)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_data(word_in),
    .pop      (pop),
    .head     (word_out),
    .full     (full),
    .empty    (empty)
  );

endmodule
